module_prio: RTL and testbench
==============================

MODULE_PRIO -- requirements
Module: module_prio

Interface
REQ-001 The block SHALL have no parameters; all widths below are fixed.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high, sampled on rising clk edge.
REQ-004 num_1  input  8  first operand (unsigned) as entered by user.
REQ-005 num_2  input  8  second operand (unsigned) as entered by user.
REQ-006 listo_1  input  1  level flag: first operand entry complete.
REQ-007 listo_2  input  1  level flag: second operand entry complete.
REQ-008 listo  input  1  level flag: multiplication result valid.
REQ-009 num_mul  input  16  product of num_1 and num_2 (unsigned), from the multiplier.
REQ-010 numero_output  output  16  value selected for display, registered.

Function
REQ-011 The block SHALL implement a display-priority selector with four states: IDLE, SHOW_1, SHOW_2, SHOW_MUL.
REQ-012 Priority, evaluated every cycle: listo highest, then listo_2, then listo_1.
REQ-013 Transitions at each rising edge:
- listo=1 -> SHOW_MUL, from any state.
- else listo_2=1 -> SHOW_2.
- else listo_1=1 -> SHOW_1.
- else (no flag asserted) -> hold current state.
REQ-014 Simultaneous flags SHALL resolve strictly by REQ-012 priority; lower flags are ignored that cycle.
REQ-015 Dropping a higher flag while a lower flag stays asserted SHALL move to the lower flag's state on the next edge.
REQ-016 Output value per next state:
- IDLE -> 16'h0000.
- SHOW_1 -> {8'h00, num_1}.
- SHOW_2 -> {8'h00, num_2}.
- SHOW_MUL -> num_mul unmodified.
REQ-017 numero_output SHALL be registered, updating one clock after the flag/data sample: flag sampled at edge N, new value visible after edge N.
REQ-018 While in a SHOW state, numero_output SHALL track the selected input every cycle; a change on num_1/num_2/num_mul appears after the next edge.
REQ-019 When all flags are deasserted, the state and the last numero_output value SHALL be held, with no return to IDLE.
REQ-020 Operands SHALL be zero-extended, never sign-extended; no arithmetic is performed inside the block.
REQ-021 Inputs not selected by the current state SHALL have no effect on numero_output.

Reset
REQ-022 With rst=1 at a rising edge, state SHALL become IDLE and numero_output SHALL become 16'h0000, regardless of flags or data.
REQ-023 rst SHALL take precedence over all flags on the same edge.
REQ-024 After rst deasserts, normal transitions SHALL begin at the next rising edge.
REQ-025 Reset asserted mid-operation, in any SHOW state, SHALL abort to IDLE/0x0000 on that edge.
REQ-026 No asynchronous reset path SHALL exist.

Verification
REQ-027 Reset: rst=1 for 1 cycle, flags 0 -> numero_output=0x0000, and it holds 0x0000 while no flag is asserted.
REQ-028 Sequence: num_1=15, num_2=10, num_mul=150; assert listo_1, then listo_2 one cycle later, then listo one cycle later (all left high) -> numero_output shows 0x000F, then 0x000A, then 0x0096, each one cycle after its flag, and holds 0x0096.
REQ-029 Priority: listo_1=listo_2=listo=1 in the same cycle with num_mul=0xFFFF -> numero_output=0xFFFF after one edge, with no intermediate 0x00xx value.
REQ-030 Hold and track:
- In SHOW_1 with num_1=0x80, output is 0x0080 (zero-extended).
- Change num_1 to 0x05 -> output is 0x0005 after the next edge.
- Deassert all flags -> 0x0005 is retained.
REQ-031 Fallback: in SHOW_MUL, drop listo while listo_2=1 and num_2=0xFF -> numero_output=0x00FF after the next edge.
REQ-032 Reset mid-operation: assert rst while in SHOW_MUL with listo=1 -> numero_output=0x0000 on that edge; after rst drops with listo still high -> num_mul reappears after one edge.

Source files
------------

// File: rtl/module_prio.sv
// Display-priority selector: picks operand 1, operand 2 or the product for display
// based on the entry/valid flags, holding the last choice once all flags drop.
module module_prio (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  num_1,
  input  logic [7:0]  num_2,
  input  logic        listo_1,
  input  logic        listo_2,
  input  logic        listo,
  input  logic [15:0] num_mul,
  output logic [15:0] numero_output
);

  localparam int unsigned OPW = 8;
  localparam int unsigned OUTW = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHOW_1   = 2'd1,
    SHOW_2   = 2'd2,
    SHOW_MUL = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [OUTW-1:0]   numero_q, numero_d;

  // State and display register; reset wins over every flag on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      numero_q <= '0;
    end else begin
      state_q  <= state_d;
      numero_q <= numero_d;
    end
  end

  // Next state by fixed priority; the output follows the selected source only
  // while some flag is up, otherwise the last displayed value is frozen.
  always_comb begin
    state_d  = state_q;
    numero_d = numero_q;
    if (listo) begin
      state_d  = SHOW_MUL;
      numero_d = num_mul;
    end else if (listo_2) begin
      state_d  = SHOW_2;
      numero_d = {(OUTW-OPW)'(0), num_2};
    end else if (listo_1) begin
      state_d  = SHOW_1;
      numero_d = {(OUTW-OPW)'(0), num_1};
    end
  end

  assign numero_output = numero_q;

endmodule

// File: tb/tb_module_prio.sv
// Self-checking bench for module_prio: vector table plus hand-written corner
// sequences, with expected values queued at drive time and checked after the edge.
module tb_module_prio;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  num_1, num_2;
  logic        listo_1, listo_2, listo;
  logic [15:0] num_mul;
  logic [15:0] numero_output;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic        l1;
    logic        l2;
    logic        l;
    logic [7:0]  n1;
    logic [7:0]  n2;
    logic [15:0] nm;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[15];

  module_prio dut (
    .clk           (clk),
    .rst           (rst),
    .num_1         (num_1),
    .num_2         (num_2),
    .listo_1       (listo_1),
    .listo_2       (listo_2),
    .listo         (listo),
    .num_mul       (num_mul),
    .numero_output (numero_output)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step(input string name, input logic r, input logic l1, input logic l2,
                      input logic l, input logic [7:0] n1, input logic [7:0] n2,
                      input logic [15:0] nm, input logic [15:0] exp);
    sb_t e;
    @(negedge clk);
    rst = r; listo_1 = l1; listo_2 = l2; listo = l;
    num_1 = n1; num_2 = n2; num_mul = nm;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    if (numero_output !== e.exp) begin
      errors++;
      $display("FAIL %s: numero_output=%h expected=%h", e.name, numero_output, e.exp);
    end
  endtask

  initial begin
    rst = 1'b1; listo_1 = 1'b0; listo_2 = 1'b0; listo = 1'b0;
    num_1 = '0; num_2 = '0; num_mul = '0;

    //         rst  l1   l2   l    n1     n2     nm        exp
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,8'd15, 8'd10, 16'd150,  16'h0000}; // reset
    vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,8'd15, 8'd10, 16'd150,  16'h0000}; // idle hold
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,8'd15, 8'd10, 16'd150,  16'h0000};
    vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,8'd15, 8'd10, 16'd150,  16'h000F}; // show 1
    vecs[4]  = '{1'b0,1'b1,1'b1,1'b0,8'd15, 8'd10, 16'd150,  16'h000A}; // show 2
    vecs[5]  = '{1'b0,1'b1,1'b1,1'b1,8'd15, 8'd10, 16'd150,  16'h0096}; // show mul
    vecs[6]  = '{1'b0,1'b1,1'b1,1'b1,8'd15, 8'd10, 16'd150,  16'h0096};
    vecs[7]  = '{1'b1,1'b1,1'b1,1'b1,8'd15, 8'd10, 16'hFFFF, 16'h0000}; // rst over flags
    vecs[8]  = '{1'b0,1'b1,1'b1,1'b1,8'd15, 8'd10, 16'hFFFF, 16'hFFFF}; // priority
    vecs[9]  = '{1'b0,1'b1,1'b0,1'b0,8'h80, 8'd10, 16'hFFFF, 16'h0080}; // zero-extend
    vecs[10] = '{1'b0,1'b1,1'b0,1'b0,8'h05, 8'd10, 16'hFFFF, 16'h0005}; // track
    vecs[11] = '{1'b0,1'b0,1'b0,1'b0,8'h05, 8'd10, 16'hFFFF, 16'h0005}; // hold
    vecs[12] = '{1'b0,1'b0,1'b0,1'b0,8'h05, 8'd10, 16'hFFFF, 16'h0005};
    vecs[13] = '{1'b0,1'b1,1'b0,1'b0,8'h05, 8'hFF, 16'h1234, 16'h0005}; // unselected
    vecs[14] = '{1'b0,1'b0,1'b1,1'b0,8'h05, 8'hC3, 16'h1234, 16'h00C3}; // sign bit

    for (int i = 0; i < 15; i++) begin
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].l1, vecs[i].l2, vecs[i].l,
           vecs[i].n1, vecs[i].n2, vecs[i].nm, vecs[i].exp);
    end

    // Fallback from SHOW_MUL to SHOW_2 when listo drops.
    step("fb_mul",   1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 8'hFF, 16'h4321, 16'h4321);
    step("fb_drop",  1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 8'hFF, 16'h4321, 16'h00FF);
    step("fb_track", 1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 8'h11, 16'h4321, 16'h0011);

    // Reset in the middle of SHOW_MUL, then recovery with listo still high.
    step("rm_mul",   1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h11, 16'hABCD, 16'hABCD);
    step("rm_rst",   1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 8'h11, 16'hABCD, 16'h0000);
    step("rm_back",  1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h11, 16'hABCD, 16'hABCD);
    step("rm_trk",   1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h11, 16'h0F0F, 16'h0F0F);

    // Reset out of SHOW_1 with flags dropped: stays IDLE at zero.
    step("ri_show1", 1'b0, 1'b1, 1'b0, 1'b0, 8'h42, 8'h11, 16'h0F0F, 16'h0042);
    step("ri_rst",   1'b1, 1'b1, 1'b0, 1'b0, 8'h42, 8'h11, 16'h0F0F, 16'h0000);
    step("ri_idle",  1'b0, 1'b0, 1'b0, 1'b0, 8'h42, 8'h11, 16'h0F0F, 16'h0000);
    step("ri_idle2", 1'b0, 1'b0, 1'b0, 1'b0, 8'h42, 8'h11, 16'h0F0F, 16'h0000);

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: left=%0d expected=0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
